// File: rtl/dw_lsd_norm_ctrl_pkg.sv
// Shared types and helpers for the leading-sign-digit normalizer.
package dw_lsd_norm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest r such that 2**r >= n (n >= 2 for every legal operand width).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dw_lsd_norm_ctrl_if.sv
// Operand/result handshake bundle for dw_lsd_norm_ctrl.
interface dw_lsd_norm_ctrl_if #(
  parameter int unsigned a_width    = 16,
  parameter int unsigned addr_width = dw_lsd_norm_ctrl_pkg::clog2(a_width)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [a_width-1:0]    in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [a_width-1:0]    out_data;
  logic [addr_width-1:0] out_cnt;
  logic                  out_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_zero
  );
endinterface

// File: rtl/dw_lsd_norm_ctrl_cnt.sv
// Redundant-sign-bit counter: number of bits below the MSB, scanning down
// from bit a_width-2, that match the MSB. Purely combinational.
module dw_lsd_cnt #(
  parameter int unsigned a_width    = 16,
  parameter int unsigned addr_width = 4
) (
  input  logic [a_width-1:0]    a,
  output logic [addr_width-1:0] cnt
);

  logic w_stop;

  // Walk downward from the bit under the sign; stop at the first mismatch.
  always_comb begin
    cnt    = '0;
    w_stop = 1'b0;
    for (int unsigned i = 1; i < a_width; i++) begin
      if (!w_stop && (a[a_width-1-i] == a[a_width-1]))
        cnt = cnt + addr_width'(1);
      else
        w_stop = 1'b1;
    end
  end

endmodule

// File: rtl/dw_lsd_norm_ctrl.sv
// Multi-cycle left normalizer: counts redundant sign bits on accept, then
// shifts left by at most shift_step per cycle until the count is consumed.
module dw_lsd_norm_ctrl
  import dw_lsd_norm_ctrl_pkg::*;
#(
  parameter int unsigned a_width    = 16,
  parameter int unsigned shift_step = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dw_lsd_norm_ctrl_if.slave      bus
);

  localparam int unsigned addr_width = clog2(a_width);
  localparam logic [addr_width-1:0] STEP = addr_width'(shift_step);

  state_t                r_state;
  logic [a_width-1:0]    r_work;
  logic [addr_width-1:0] r_rem;
  logic [addr_width-1:0] r_cnt;
  logic                  r_zero;
  logic                  r_out_valid;
  logic                  r_in_ready;

  logic [addr_width-1:0] w_cnt;
  logic [addr_width-1:0] w_amt;
  logic [addr_width-1:0] w_rem_next;

  dw_lsd_cnt #(
    .a_width    (a_width),
    .addr_width (addr_width)
  ) u_cnt (
    .a   (bus.in_data),
    .cnt (w_cnt)
  );

  // Per-cycle shift amount: min(remaining, shift_step).
  always_comb begin
    w_amt      = (r_rem > STEP) ? STEP : r_rem;
    w_rem_next = r_rem - w_amt;
  end

  // FSM with working register, remaining counter and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_work     <= bus.in_data;
            r_rem      <= w_cnt;
            r_cnt      <= w_cnt;
            r_zero     <= (bus.in_data == '0);
            r_in_ready <= 1'b0;
            if (w_cnt == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= r_work << w_amt;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_work;
  assign bus.out_cnt   = r_cnt;
  assign bus.out_zero  = r_zero;

endmodule

// File: doc/dw_lsd_norm_ctrl.md
DW_LSD_NORM_CTRL -- requirements
Module: dw_lsd_norm_ctrl

Interface
REQ-001: Parameter a_width, default 16, operand width in bits; legal range 4..256.
REQ-002: Parameter shift_step, default 4, maximum left-shift applied per cycle; legal range 1..a_width-1.
REQ-003: Derived constant addr_width = ceil(log2(a_width)), width of the shift-count output.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: rst_n  input  1  reset, asynchronous and active-low.
REQ-006: in_valid  input  1  operand on in_data is offered.
REQ-007: in_ready  output  1  block accepts an operand this cycle.
REQ-008: in_data  input  a_width  two's-complement operand.
REQ-009: out_valid  output  1  result on out_data/out_cnt/out_zero is valid.
REQ-010: out_ready  input  1  consumer takes the result this cycle.
REQ-011: out_data  output  a_width  normalized operand.
REQ-012: out_cnt  output  addr_width  total left-shift applied, equal to the redundant-sign-bit count.
REQ-013: out_zero  output  1  operand was all zeros.

Function
REQ-014: The redundant-sign-bit count c shall equal the number of consecutive bits, starting at bit a_width-2 and moving downward, that equal bit a_width-1; for all-zero and all-one operands, c = a_width-1.
REQ-015: The FSM shall have three states: IDLE, SHIFT and DONE.
REQ-016: IDLE: in_ready=1. On in_valid, capture in_data, compute c, set remaining=c and out_cnt=c, and set out_zero to (in_data==0). Next state is DONE if c==0, else SHIFT.
REQ-017: SHIFT: each cycle, shift the working register left by min(remaining, shift_step) with zero fill, and subtract the same amount from remaining. Go to DONE when remaining reaches 0.
REQ-018: DONE: out_valid=1; hold out_data, out_cnt and out_zero stable until out_ready=1, then go to IDLE.
REQ-019: in_ready shall be 1 only in IDLE; the block never accepts a new operand in the same cycle a result is taken.
REQ-020: Latency from the accepting edge to out_valid=1 shall be exactly 1+ceil(c/shift_step) cycles.
REQ-021: The sign bit of out_data shall equal the sign bit of in_data, except for the all-zero operand.
REQ-022: Changes on in_data or in_valid outside IDLE shall have no effect.
REQ-023: out_valid and in_ready shall be driven directly from the state register, with no combinational path from in_valid or out_ready.

Reset
REQ-024: When rst_n=0: state=IDLE; working register, remaining, out_cnt and out_zero are cleared to 0.
REQ-025: After reset, out_valid=0 and in_ready=1.
REQ-026: Reset asserted in SHIFT or DONE shall abort the operation with no output; the first edge after deassertion behaves as IDLE.

Structure
REQ-027: A shared package shall hold the FSM state enumeration (IDLE, SHIFT, DONE) and the addr_width ceil-log2 helper.
REQ-028: The count of REQ-014 shall be computed in one purely combinational sub-module, dw_lsd_cnt (inputs a; output cnt[addr_width]), instantiated once.
REQ-029: The top level shall contain only the FSM, the working shift register, the remaining counter and the output registers.

Verification (a_width=16, shift_step=4)
REQ-030: in_data=0x4000 -> out_data=0x4000, out_cnt=0, out_zero=0; out_valid 1 cycle after accept.
REQ-031: in_data=0x0001 -> out_data=0x4000, out_cnt=14; out_valid 5 cycles after accept (shifts 4,4,4,2).
REQ-032: in_data=0xFFF0 -> out_data=0x8000, out_cnt=11; out_valid 4 cycles after accept.
REQ-033: in_data=0x0000 -> out_data=0x0000, out_cnt=15, out_zero=1; out_valid after 5 cycles.
REQ-034: Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, and new in_valid is ignored. out_ready=1 -> IDLE next cycle.
REQ-035: Pulse rst_n low during SHIFT for in_data=0x0001 -> out_valid never asserts; in_ready=1 after release; the next operand 0x2000 yields out_cnt=1 and out_data=0x4000.
